// File: rtl/boot_pkg.sv
// Shared types and constants for the stream-driven memory image loader.
// Imported by mem_boot_loader and boot_wr_port.
package boot_pkg;

  localparam int unsigned DefaultAddrW = 16;

  localparam logic [7:0] CmdWrite = 8'hA5;
  localparam logic [7:0] CmdRun   = 8'h5A;

  typedef enum logic [3:0] {
    StWaitCmd,
    StAddrH,
    StAddrL,
    StLenH,
    StLenL,
    StData,
    StCsum,
    StRun,
    StHalt
  } boot_state_e;

endpackage

// File: rtl/boot_wr_port.sv
// Registered memory write port: holds the running write address and
// presents one-cycle write pulses with the registered address and data.
module boot_wr_port
  import boot_pkg::*;
#(
  parameter int unsigned AddrW = DefaultAddrW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [AddrW-1:0] load_addr_i,
  input  logic             wr_i,
  input  logic [7:0]       wr_data_i,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [7:0]       mem_wdata_o
);

  logic [AddrW-1:0] next_addr_q, next_addr_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             we_q, we_d;

  always_comb begin
    next_addr_d = next_addr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = wr_i;
    if (load_i) begin
      next_addr_d = load_addr_i;
    end
    if (wr_i) begin
      addr_d      = next_addr_q;
      wdata_d     = wr_data_i;
      // Natural overflow gives the FFFF -> 0000 wrap inside a block.
      next_addr_d = next_addr_q + AddrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      next_addr_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
    end else begin
      next_addr_q <= next_addr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end

  // A pulse already registered is suppressed during the reset cycle itself.
  assign mem_we_o    = we_q & ~rst_i;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: rtl/mem_boot_loader.sv
// Framed byte-stream image loader: writes payload bytes into memory and
// holds the CPU in reset until a RUN command; re-arms after the CPU halts.
module mem_boot_loader
  import boot_pkg::*;
#(
  parameter int unsigned AddrW = DefaultAddrW
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [7:0]       s_data_i,
  input  logic             hcf_i,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [7:0]       mem_wdata_o,
  output logic             cpu_rst_o,
  output logic             busy_o,
  output logic             err_o
);

  boot_state_e state_q, state_d;
  logic [7:0]  addr_hi_q, addr_hi_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  sum_q, sum_d;
  logic        err_q, err_d;

  logic             xfer;
  logic             load;
  logic             wr;
  logic [AddrW-1:0] load_addr;
  logic [15:0]      len_full;

  assign s_ready_o = (state_q != StRun) && (state_q != StHalt);
  assign xfer      = s_valid_i & s_ready_o;
  assign len_full  = {len_hi_q, s_data_i};
  assign load_addr = AddrW'({addr_hi_q, s_data_i});

  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    len_hi_d  = len_hi_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    err_d     = err_q;
    load      = 1'b0;
    wr        = 1'b0;

    unique case (state_q)
      StWaitCmd: begin
        if (xfer) begin
          if (s_data_i == CmdWrite) begin
            state_d = StAddrH;
            sum_d   = 8'h00;
          end else if (s_data_i == CmdRun) begin
            state_d = StRun;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StAddrH: begin
        if (xfer) begin
          addr_hi_d = s_data_i;
          sum_d     = sum_q + s_data_i;
          state_d   = StAddrL;
        end
      end
      StAddrL: begin
        if (xfer) begin
          load    = 1'b1;
          sum_d   = sum_q + s_data_i;
          state_d = StLenH;
        end
      end
      StLenH: begin
        if (xfer) begin
          len_hi_d = s_data_i;
          sum_d    = sum_q + s_data_i;
          state_d  = StLenL;
        end
      end
      StLenL: begin
        if (xfer) begin
          sum_d = sum_q + s_data_i;
          if (len_full == 16'h0000) begin
            state_d = StCsum;
          end else begin
            cnt_d   = len_full;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          wr    = 1'b1;
          sum_d = sum_q + s_data_i;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (xfer) begin
          if (s_data_i != sum_q) begin
            err_d = 1'b1;
          end
          state_d = StWaitCmd;
        end
      end
      StRun: begin
        if (hcf_i) begin
          state_d = StHalt;
        end
      end
      StHalt: begin
        state_d = StWaitCmd;
      end
      default: begin
        state_d = StWaitCmd;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StWaitCmd;
      addr_hi_q <= 8'h00;
      len_hi_q  <= 8'h00;
      cnt_q     <= 16'h0000;
      sum_q     <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      len_hi_q  <= len_hi_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
    end
  end

  assign cpu_rst_o = (state_q != StRun);
  assign busy_o    = (state_q != StWaitCmd) && (state_q != StRun);
  assign err_o     = err_q;

  boot_wr_port #(
    .AddrW(AddrW)
  ) u_wr_port (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .load_addr_i(load_addr),
    .wr_i       (wr),
    .wr_data_i  (s_data_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o)
  );

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: a frame-level model predicts writes and
// status outputs, checked every cycle, plus literal checks of memory contents.
module tb_mem_boot_loader;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_valid_i = 1'b0;
  logic        s_ready_o;
  logic [7:0]  s_data_i = 8'h00;
  logic        hcf_i = 1'b0;
  logic        mem_we_o;
  logic [15:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        cpu_rst_o;
  logic        busy_o;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  mem_boot_loader #(
    .AddrW(16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .hcf_i      (hcf_i),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .cpu_rst_o  (cpu_rst_o),
    .busy_o     (busy_o),
    .err_o      (err_o)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  int n_checks = 0;
  int n_fail = 0;

  // Frame-level model state.
  logic       exp_err = 1'b0;
  logic       exp_cpu_rst = 1'b1;
  logic       exp_ready = 1'b1;
  logic       exp_busy = 1'b0;
  wr_t        exp_wr_q[$];
  logic [7:0] pay_q[$];
  logic [7:0] shadow [65536];
  int         we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk_i) begin
    if (rst_i) begin
      check("we_during_rst", 32'(mem_we_o), 0);
      exp_wr_q.delete();
    end else begin
      check("s_ready", 32'(s_ready_o), 32'(exp_ready));
      check("cpu_rst", 32'(cpu_rst_o), 32'(exp_cpu_rst));
      check("busy", 32'(busy_o), 32'(exp_busy));
      check("err", 32'(err_o), 32'(exp_err));
      check("mem_we", 32'(mem_we_o), 32'(exp_wr_q.size() != 0));
      if (mem_we_o) begin
        shadow[mem_addr_o] = mem_wdata_o;
        we_count++;
      end
      if (mem_we_o && exp_wr_q.size() != 0) begin
        check("mem_addr", 32'(mem_addr_o), 32'(exp_wr_q[0].a));
        check("mem_wdata", 32'(mem_wdata_o), 32'(exp_wr_q[0].d));
      end
      if (exp_wr_q.size() != 0) void'(exp_wr_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid_i = 1'b1;
    s_data_i  = b;
    tick();
    s_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    s_valid_i = 1'b0;
    hcf_i     = 1'b0;
    tick();
    tick();
    rst_i       = 1'b0;
    exp_err     = 1'b0;
    exp_cpu_rst = 1'b1;
    exp_ready   = 1'b1;
    exp_busy    = 1'b0;
    exp_wr_q.delete();
  endtask

  // Sends a WRITE frame of pay_q; stop_after >= 0 abandons it after that many data bytes.
  task automatic write_frame(input logic [15:0] addr, input logic [7:0] csum,
                             input int stop_after);
    logic [7:0]  sum;
    logic [15:0] len;
    len = 16'(pay_q.size());
    sum = 8'h00;
    send(8'hA5);
    exp_busy = 1'b1;
    send(addr[15:8]);
    send(addr[7:0]);
    send(len[15:8]);
    send(len[7:0]);
    sum = addr[15:8] + addr[7:0] + len[15:8] + len[7:0];
    for (int i = 0; i < pay_q.size(); i++) begin
      if (i == stop_after) return;
      send(pay_q[i]);
      exp_wr_q.push_back('{a: 16'(addr + 16'(i)), d: pay_q[i]});
      sum = sum + pay_q[i];
    end
    send(csum);
    exp_busy = 1'b0;
    if (csum != sum) exp_err = 1'b1;
  endtask

  initial begin
    int base;
    do_reset();
    check("rst_mem_addr", 32'(mem_addr_o), 0);
    check("rst_mem_wdata", 32'(mem_wdata_o), 0);
    check("rst_cpu_rst", 32'(cpu_rst_o), 1);
    check("rst_s_ready", 32'(s_ready_o), 1);

    // 1: three bytes at 0x0010.
    we_count = 0;
    pay_q = '{8'h11, 8'h22, 8'h33};
    write_frame(16'h0010, 8'h79, -1);
    tick();
    tick();
    check("t1_mem10", 32'(shadow[16'h0010]), 32'h11);
    check("t1_mem11", 32'(shadow[16'h0011]), 32'h22);
    check("t1_mem12", 32'(shadow[16'h0012]), 32'h33);
    check("t1_we_count", 32'(we_count), 3);
    check("t1_err", 32'(err_o), 0);

    // 2: address wrap; checksum FF+FE+00+04+01+02+03+04 = 0x20B -> 0x0B.
    do_reset();
    pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    write_frame(16'hFFFE, 8'h0B, -1);
    tick();
    tick();
    check("t2_memFFFE", 32'(shadow[16'hFFFE]), 32'h01);
    check("t2_memFFFF", 32'(shadow[16'hFFFF]), 32'h02);
    check("t2_mem0000", 32'(shadow[16'h0000]), 32'h03);
    check("t2_mem0001", 32'(shadow[16'h0001]), 32'h04);
    check("t2_err", 32'(err_o), 0);

    // 3: bad checksum still writes, sets err; RUN releases the CPU.
    do_reset();
    shadow[16'h0010] = 8'h00;
    shadow[16'h0011] = 8'h00;
    shadow[16'h0012] = 8'h00;
    pay_q = '{8'h11, 8'h22, 8'h33};
    write_frame(16'h0010, 8'h00, -1);
    tick();
    check("t3_mem11", 32'(shadow[16'h0011]), 32'h22);
    check("t3_err", 32'(err_o), 1);
    send(8'h5A);
    exp_cpu_rst = 1'b0;
    exp_ready   = 1'b0;
    check("t3_cpu_rst", 32'(cpu_rst_o), 0);

    // 4: halt while running, then re-arm.
    tick();
    tick();
    hcf_i = 1'b1;
    tick();
    hcf_i       = 1'b0;
    exp_cpu_rst = 1'b1;
    exp_busy    = 1'b1;
    check("t4_cpu_rst_after_hcf", 32'(cpu_rst_o), 1);
    check("t4_s_ready_halt", 32'(s_ready_o), 0);
    tick();
    exp_ready = 1'b1;
    exp_busy  = 1'b0;
    check("t4_s_ready_rearmed", 32'(s_ready_o), 1);
    hcf_i = 1'b1;  // ignored outside RUN
    tick();
    hcf_i = 1'b0;
    send(8'h5A);
    exp_cpu_rst = 1'b0;
    exp_ready   = 1'b0;
    tick();
    check("t4_rerun_cpu_rst", 32'(cpu_rst_o), 0);

    // 5: bad opcode, then an empty block.
    do_reset();
    send(8'h3C);
    exp_err = 1'b1;
    check("t5_err", 32'(err_o), 1);
    check("t5_busy", 32'(busy_o), 0);
    base = we_count;
    pay_q.delete();
    write_frame(16'h0000, 8'h00, -1);
    tick();
    check("t5_no_we", 32'(we_count - base), 0);
    check("t5_err_sticky", 32'(err_o), 1);

    // 6: reset after two of three data bytes; the third byte is offered during reset.
    do_reset();
    shadow[16'h0012] = 8'hEE;
    base = we_count;
    pay_q = '{8'h11, 8'h22, 8'h33};
    write_frame(16'h0010, 8'h79, 2);
    tick();
    rst_i     = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 8'h33;
    tick();
    s_valid_i = 1'b0;
    tick();
    rst_i       = 1'b0;
    exp_err     = 1'b0;
    exp_cpu_rst = 1'b1;
    exp_ready   = 1'b1;
    exp_busy    = 1'b0;
    exp_wr_q.delete();
    tick();
    check("t6_we_count", 32'(we_count - base), 2);
    check("t6_no_third", 32'(shadow[16'h0012]), 32'hEE);
    check("t6_busy", 32'(busy_o), 0);
    check("t6_err", 32'(err_o), 0);
    check("t6_cpu_rst", 32'(cpu_rst_o), 1);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
